// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format and a first-word-fall-through output FIFO.
// Errored frames are still queued; overrun pulses when a finished frame finds the FIFO full.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS   = 7,
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          frame_err_out,
    output logic                          parity_err_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          overrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state_out
);

    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = 1'(PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 frame_err;
        logic                 parity_err;
    } word_t;

    logic                 rx_meta_q;
    logic                 rx_s_q;
    state_e               state_q;
    logic [CNT_W-1:0]     tick_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 push_q;
    word_t                push_word_q;

    word_t                mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q;
    logic [PTR_W-1:0]     rd_q;
    logic [CNTF_W-1:0]    count_q;
    logic [CNTF_W-1:0]    count_d;
    logic                 overrun_q;
    logic                 fifo_full;
    logic                 do_push;
    logic                 do_pop;
    word_t                head;

    // Two-flop synchroniser on the pad, idle-high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM: advances only on enabled oversample ticks; push_q is a one-clk strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (ena) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!rx_s_q) begin
                            state_q <= S_START;
                            tick_q  <= '0;
                        end
                    end
                    S_START: begin
                        if (tick_q == MID_TICK) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            stop_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            perr_q  <= 1'b0;
                            state_q <= rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            tick_q <= tick_q + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == LAST_BIT) begin
                                state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end else begin
                            tick_q <= tick_q + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            perr_q  <= (^shift_q) ^ rx_s_q ^ ODD_PAR;
                            state_q <= S_STOP;
                        end else begin
                            tick_q <= tick_q + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (tick_q == LAST_TICK) begin
                            tick_q <= '0;
                            if (stop_q == LAST_STOP) begin
                                push_q      <= 1'b1;
                                push_word_q <= '{data:       shift_q,
                                                 frame_err:  ferr_q | ~rx_s_q,
                                                 parity_err: perr_q};
                                state_q     <= S_IDLE;
                            end else begin
                                ferr_q <= ferr_q | ~rx_s_q;
                                stop_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO only drops when nothing pops.
    assign fifo_full = (count_q == CNTF_W'(FIFO_DEPTH));
    assign valid_out = (count_q != '0);
    assign do_pop    = valid_out && ready_in;
    assign do_push   = push_q && (!fifo_full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNTF_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNTF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= push_q && fifo_full && !do_pop;
            if (do_push) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_word_q;
        end
    end

    assign head           = mem_q[rd_q];
    assign data_out       = valid_out ? head.data : '0;
    assign frame_err_out  = valid_out ? head.frame_err : 1'b0;
    assign parity_err_out = valid_out ? head.parity_err : 1'b0;
    assign overrun_out    = overrun_q;
    assign fifo_count     = count_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: dut0 is the default 7N1 receiver, dut1 is 8-bit even parity.
module tb_uart_rx_fifo;

    localparam int OS = 8;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       ready;
    logic       rx0;
    logic       rx1;
    bit         ena_rand;

    logic [6:0] d0;
    logic       fe0, pe0, v0, ov0;
    logic [2:0] cnt0, st0;
    logic [7:0] d1;
    logic       fe1, pe1, v1, ov1;
    logic [2:0] cnt1, st1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t me0, me1;
    int   checks   = 0;
    int   failures = 0;
    int   pops0    = 0;
    int   pops1    = 0;
    int   ovr0     = 0;
    int   ovr1     = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut0 (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx0),
        .data_out(d0), .frame_err_out(fe0), .parity_err_out(pe0),
        .valid_out(v0), .ready_in(ready), .overrun_out(ov0),
        .fifo_count(cnt0), .state_out(st0)
    );

    uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx1),
        .data_out(d1), .frame_err_out(fe1), .parity_err_out(pe1),
        .valid_out(v1), .ready_in(ready), .overrun_out(ov1),
        .fifo_count(cnt1), .state_out(st1)
    );

    always @(negedge clk) begin
        ena = ena_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Scoreboard: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (v0 === 1'b1 && ready === 1'b1) begin
                checks++;
                pops0++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL pop0_unexpected got data=%h fe=%b pe=%b", d0, fe0, pe0);
                end else begin
                    me0 = q0.pop_front();
                    if ({d0, fe0, pe0} !== {me0.data[6:0], me0.fe, me0.pe}) begin
                        failures++;
                        $display("FAIL pop0_word got data=%h fe=%b pe=%b want data=%h fe=%b pe=%b",
                                 d0, fe0, pe0, me0.data[6:0], me0.fe, me0.pe);
                    end
                end
            end
            if (v1 === 1'b1 && ready === 1'b1) begin
                checks++;
                pops1++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL pop1_unexpected got data=%h fe=%b pe=%b", d1, fe1, pe1);
                end else begin
                    me1 = q1.pop_front();
                    if ({d1, fe1, pe1} !== {me1.data[7:0], me1.fe, me1.pe}) begin
                        failures++;
                        $display("FAIL pop1_word got data=%h fe=%b pe=%b want data=%h fe=%b pe=%b",
                                 d1, fe1, pe1, me1.data[7:0], me1.fe, me1.pe);
                    end
                end
            end
            if (ov0 === 1'b1) ovr0++;
            if (ov1 === 1'b1) ovr1++;
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (ena) k++;
        end
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Drives one frame; the expectation is queued once the payload has been sampled.
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int pmode, input logic pflip, input logic stop_ok,
                              input logic expect_push);
        logic p;
        exp_t e;
        set_rx(which, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            wait_ticks(OS);
        end
        p = ((pmode == 2) ? ~(^data) : (^data)) ^ pflip;
        if (pmode != 0) begin
            set_rx(which, p);
            wait_ticks(OS);
        end
        e.data = data;
        e.fe   = ~stop_ok;
        e.pe   = (pmode == 0) ? 1'b0 : ((^data) ^ p ^ (pmode == 2));
        if (expect_push) begin
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        if (stop_ok) begin
            set_rx(which, 1'b1);
            wait_ticks(OS);
        end else begin
            set_rx(which, 1'b0);
            wait_ticks(OS / 2);
            set_rx(which, 1'b1);
            wait_ticks(OS / 2);
        end
    endtask

    task automatic wait_drain(input int which);
        int n = 0;
        while (n < 2000 && ((which == 0) ? (q0.size() != 0 || cnt0 != 0)
                                         : (q1.size() != 0 || cnt1 != 0))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL drain%0d_timeout got pending=%0d want 0", which,
                     (which == 0) ? q0.size() : q1.size());
        end
    endtask

    task automatic test_reset();
        ready = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ena_rand = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (st0 !== 3'd0)  begin failures++; $display("FAIL rst_state0 got %0d want 0", st0); end
        checks++; if (v0 !== 1'b0)   begin failures++; $display("FAIL rst_valid0 got %b want 0", v0); end
        checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL rst_count0 got %0d want 0", cnt0); end
        checks++; if ({d0, fe0, pe0, ov0} !== 10'd0) begin
            failures++; $display("FAIL rst_outs0 got %h want 0", {d0, fe0, pe0, ov0});
        end
        checks++; if ({st1, v1, cnt1, d1, fe1, pe1, ov1} !== 18'd0) begin
            failures++; $display("FAIL rst_outs1 got %h want 0", {st1, v1, cnt1, d1, fe1, pe1, ov1});
        end
    endtask

    task automatic test_basic();
        int p = pops0;
        ready = 1'b1;
        send_frame(0, 9'h02D, 7, 0, 1'b0, 1'b1, 1'b1);
        wait_drain(0);
        checks++; if (pops0 != p + 1) begin failures++; $display("FAIL basic_pops got %0d want %0d", pops0 - p, 1); end
        checks++; if (cnt0 !== 3'd0)  begin failures++; $display("FAIL basic_count got %0d want 0", cnt0); end
    endtask

    task automatic test_glitch();
        int p = pops0;
        ready = 1'b1;
        wait_ticks(1);
        rx0 = 1'b0;
        wait_ticks(3);
        checks++; if (st0 !== 3'd1) begin failures++; $display("FAIL glitch_start got %0d want 1", st0); end
        rx0 = 1'b1;
        wait_ticks(2 * OS);
        checks++; if (st0 !== 3'd0)  begin failures++; $display("FAIL glitch_idle got %0d want 0", st0); end
        checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL glitch_count got %0d want 0", cnt0); end
        checks++; if (pops0 != p)    begin failures++; $display("FAIL glitch_pops got %0d want 0", pops0 - p); end
    endtask

    task automatic test_parity();
        int p = pops1;
        ready = 1'b1;
        send_frame(1, 9'h0A5, 8, 1, 1'b0, 1'b1, 1'b1);
        send_frame(1, 9'h0A5, 8, 1, 1'b1, 1'b1, 1'b1);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1'b1, 1'b1);
        wait_drain(1);
        checks++; if (pops1 != p + 3) begin failures++; $display("FAIL parity_pops got %0d want 3", pops1 - p); end
    endtask

    task automatic test_frame_err();
        int p = pops0;
        ready = 1'b1;
        send_frame(0, 9'h07F, 7, 0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h001, 7, 0, 1'b0, 1'b1, 1'b1);
        wait_drain(0);
        checks++; if (pops0 != p + 2) begin failures++; $display("FAIL ferr_pops got %0d want 2", pops0 - p); end
    endtask

    task automatic test_overrun();
        int p  = pops0;
        int ov = ovr0;
        int want;
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 7, 0, 1'b0, 1'b1, i <= 4);
            wait_ticks(2);
            want = (i < 4) ? i : 4;
            checks++;
            if (cnt0 !== 3'(want)) begin
                failures++; $display("FAIL ovr_count%0d got %0d want %0d", i, cnt0, want);
            end
        end
        checks++; if (ovr0 != ov + 1) begin failures++; $display("FAIL ovr_pulses got %0d want 1", ovr0 - ov); end
        ready = 1'b1;
        wait_drain(0);
        checks++; if (pops0 != p + 4) begin failures++; $display("FAIL ovr_pops got %0d want 4", pops0 - p); end
    endtask

    task automatic test_reset_mid();
        int p;
        ready = 1'b0;
        send_frame(0, 9'h011, 7, 0, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h022, 7, 0, 1'b0, 1'b1, 1'b1);
        wait_ticks(2);
        checks++; if (cnt0 !== 3'd2) begin failures++; $display("FAIL rmid_count_pre got %0d want 2", cnt0); end
        rx0 = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx0 = i[0];
            wait_ticks(OS);
        end
        checks++; if (st0 !== 3'd2) begin failures++; $display("FAIL rmid_state_pre got %0d want 2", st0); end
        rst = 1'b1; rx0 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        checks++; if (v0 !== 1'b0)   begin failures++; $display("FAIL rmid_valid got %b want 0", v0); end
        checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL rmid_count got %0d want 0", cnt0); end
        checks++; if (st0 !== 3'd0)  begin failures++; $display("FAIL rmid_state got %0d want 0", st0); end
        wait_ticks(2 * OS);
        p = pops0;
        ready = 1'b1;
        send_frame(0, 9'h033, 7, 0, 1'b0, 1'b1, 1'b1);
        wait_drain(0);
        checks++; if (pops0 != p + 1) begin failures++; $display("FAIL rmid_pops got %0d want 1", pops0 - p); end
    endtask

    task automatic test_back_to_back();
        int  p0 = pops0;
        int  p1 = pops1;
        int  ov = ovr0 + ovr1;
        bit  done = 1'b0;
        ena_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_frame(0, 9'($urandom_range(0, 127)), 7, 0, 1'b0, 1'b1, 1'b1);
            end
            begin
                for (int i = 0; i < 4; i++)
                    send_frame(1, 9'($urandom_range(0, 255)), 8, 1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 ready = 1'($urandom_range(0, 1));
                    if (q0.size() == 0 && q1.size() == 0 && pops0 >= p0 + 6 && pops1 >= p1 + 4) done = 1'b1;
                    if ($time > 1500000) done = 1'b1;
                end
            end
        join_any
        wait fork;
        ready = 1'b1;
        ena_rand = 1'b0;
        wait_drain(0);
        wait_drain(1);
        checks++; if (pops0 != p0 + 6) begin failures++; $display("FAIL b2b_pops0 got %0d want 6", pops0 - p0); end
        checks++; if (pops1 != p1 + 4) begin failures++; $display("FAIL b2b_pops1 got %0d want 4", pops1 - p1); end
        checks++; if (ovr0 + ovr1 != ov) begin failures++; $display("FAIL b2b_overrun got %0d want 0", ovr0 + ovr1 - ov); end
    endtask

    initial begin
        ready = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rst = 1'b1; ena_rand = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the team's fixed 7-bit Hamming receiver. Adds configurable data width, oversampling ratio, parity mode, stop-bit count and an output FIFO with valid/ready handshake, plus per-word error flags. It sits between the rx pad and the Hamming(7,4) decoder, or any wider consumer, and absorbs consumer back-pressure.

Parameters:
DATA_BITS, 7, data bits per frame, LSB first; legal range 5..9.
OVERSAMPLE, 8, enabled clock cycles per bit; even, 4..16.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, output FIFO entries; power of 2, 2..16.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  sample enable; each enabled cycle is one oversample tick
rx  in  1  UART line; idle high, start low, stop high
data_out  out  DATA_BITS  FIFO head data
frame_err_out  out  1  FIFO head: a stop bit was sampled low
parity_err_out  out  1  FIFO head: parity mismatch; always 0 when PARITY_MODE = 0
valid_out  out  1  FIFO non-empty
ready_in  in  1  consumer accepts the head word when valid_out && ready_in
overrun_out  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full
fifo_count  out  clog2(FIFO_DEPTH)+1  number of stored words
state_out  out  3  FSM state, for debug

Behaviour:
- Reset: one clk with rst = 1, synchronous, takes priority over everything. Clears FSM to IDLE, all counters, FIFO pointers and count, all outputs to 0. The rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser clocked every clk, independent of ena; the FSM uses the synchronised value rx_s.
- ena = 0: FSM, counters and the push side hold. The FIFO pop side still operates.
- FSM state encoding: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4.
- IDLE -> START on the first enabled tick with rx_s = 0; the sample counter clears.
- START: count OVERSAMPLE/2 - 1 further ticks to reach mid-bit.
  - rx_s = 0 at mid-bit: go to DATA, counter clears.
  - rx_s = 1 at mid-bit: glitch; return to IDLE with no push and no flags.
- DATA: sample rx_s every OVERSAMPLE ticks, at bit centres. Shift into a DATA_BITS register, LSB first. After DATA_BITS samples go to PARITY if PARITY_MODE != 0, otherwise to STOP.
- PARITY: sample one bit.
  - Even: error if XOR(data, parity bit) = 1.
  - Odd: error if XOR(data, parity bit) = 0.
- STOP: sample STOP_BITS bits. frame_err = 1 if any stop sample is 0. At the final stop sample, push {data, frame_err, parity_err} and go to IDLE on the same tick. IDLE can therefore detect the next start bit on the next enabled tick.
- Frames with errors are still pushed; the consumer decides what to do with them.
- Frame-end to valid_out latency: 1 clk; the push registers, and valid_out follows from the count.
- FIFO: first-word-fall-through. Outputs show entry[rd_ptr] whenever valid_out = 1. Outputs are 0 when empty.
- Pop when valid_out && ready_in. ready_in while empty is ignored.
- Push and pop in the same cycle: both happen and the count is unchanged. When full, a simultaneous pop frees the slot, so the push succeeds with no overrun.
- Push when full with no pop: the new word is dropped, overrun_out pulses for one clk, and stored contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- rst mid-frame: the partial frame is discarded and the FIFO is emptied.
- The line being held low (break) produces frames of data 0 with frame_err = 1; the FSM then waits in IDLE for the next low sample.

Test Plan:
- Defaults: send 7-bit 0x2D (bits 1,0,1,1,0,1,0 LSB first), stop = 1, ready_in = 1 -> one valid_out pulse, data_out = 0x2D, both error flags 0, fifo_count returns to 0.
- Glitch: rx low for 3 enabled ticks, then high (OVERSAMPLE = 8) -> FSM returns to IDLE, no valid_out, fifo_count stays 0.
- PARITY_MODE = 1, DATA_BITS = 8: send 0xA5 with parity 0 -> parity_err_out = 0. Send 0xA5 with parity 1 -> data_out = 0xA5, parity_err_out = 1.
- Stop bit sampled low on 0x7F -> word is pushed with data_out = 0x7F and frame_err_out = 1. The next good frame 0x01 is received correctly.
- ready_in = 0, send 5 frames 0x01..0x05 with FIFO_DEPTH = 4 -> fifo_count = 4 and one overrun_out pulse on the 5th. Then ready_in = 1 -> data pops in order 0x01..0x04.
- Assert rst for 1 clk mid-DATA with 2 words queued -> valid_out = 0, fifo_count = 0, state_out = 0 next cycle. A following frame 0x33 is received cleanly.
